vx_commit_arbiter: RTL and testbench
====================================

// Module: vx_commit_arbiter
// PURPOSE
//  Parametrised commit/writeback merger for the execute stage. Collects commit packets from
//  NUM_INPUTS functional units (alu, lsu ld/st, csr, fpu, gpu, ...) through per-unit elastic
//  buffers and drains them onto NUM_OUTPUTS writeback ports with round-robin fairness.
//  Also produces registered per-cycle retired-thread counts for the CSR instret counters.
// PARAMETERS
//  NUM_INPUTS   5   commit sources; >=2, need not be a power of 2
//  NUM_OUTPUTS  1   writeback ports; 1 <= NUM_OUTPUTS <= NUM_INPUTS
//  NUM_THREADS  4   lanes per warp
//  NUM_WARPS    4   warps per core; WW = max(1,clog2(NUM_WARPS))
//  BUF_DEPTH    2   entries per input buffer; power of 2, >=2
//  CW = clog2(NUM_OUTPUTS*NUM_THREADS+1); PKT = WW+NUM_THREADS+32+5+1+NUM_THREADS*32+1
// PORTS
//  clk        in   1                      clock
//  reset      in   1                      synchronous, active-high
//  in_valid   in   NUM_INPUTS             per-source packet valid
//  in_ready   out  NUM_INPUTS             per-source buffer not full
//  in_wid     in   NUM_INPUTS*WW          warp id
//  in_tmask   in   NUM_INPUTS*NUM_THREADS thread mask
//  in_pc      in   NUM_INPUTS*32          instruction PC
//  in_rd      in   NUM_INPUTS*5           destination register
//  in_wb      in   NUM_INPUTS             register writeback enable
//  in_data    in   NUM_INPUTS*NUM_THREADS*32  per-lane result
//  in_eop     in   NUM_INPUTS             end of packet (last beat of instruction)
//  out_valid  out  NUM_OUTPUTS            writeback slot valid
//  out_ready  in   NUM_OUTPUTS            writeback consumer ready
//  out_src    out  NUM_OUTPUTS*clog2(NUM_INPUTS)  source index of packet in slot
//  out_wid/out_tmask/out_pc/out_rd/out_wb/out_data/out_eop  out  NUM_OUTPUTS x field  packet fields
//  cmt_valid  out  1                      >=1 eop packet retired last cycle
//  cmt_count  out  CW                     threads retired last cycle
//  busy       out  1                      any buffer or output slot occupied
// BEHAVIOUR
//  - Reset: buffers empty, rr_ptr=0, out_valid=0, cmt_valid=0, cmt_count=0, busy=0; in_ready=0
//    while reset high, all-ones the cycle after. Reset mid-operation discards all in-flight packets.
//  - Input fire: in_valid[i]&&in_ready[i]; packet written at buffer tail next edge. in_ready[i] =
//    (count[i] != BUF_DEPTH) from registered count; a pop in the same cycle does NOT raise ready.
//  - Output slot k loads when !out_valid[k] || out_ready[k]; holds all fields stable while
//    out_valid[k] && !out_ready[k]. Fire = out_valid[k] && out_ready[k].
//  - Grant: scan inputs from rr_ptr upward modulo NUM_INPUTS; each non-empty head is assigned to
//    the lowest-indexed loadable slot not yet assigned this cycle; scan stops when slots exhausted.
//    At most one packet per input per cycle. Granted heads pop at the same edge the slot loads.
//  - rr_ptr <= (last granted index + 1) mod NUM_INPUTS; unchanged when no grant. Wraps at
//    NUM_INPUTS-1 -> 0 for non-power-of-2 counts.
//  - Latency: input fire at cycle t -> out_valid at t+2 with empty pipeline and ready consumer.
//    Full throughput: NUM_OUTPUTS packets/cycle sustained when >= NUM_OUTPUTS inputs backlogged.
//  - Packets from one input leave in arrival order; no ordering across inputs.
//  - Stats: cycle after output fires, cmt_count = sum over fired slots with eop=1 of
//    popcount(tmask); cmt_valid = (any such slot). Non-eop beats count 0.
//  - busy = |count[*] || |out_valid; registered-state derived, no combinational input path.
//  - No combinational path from in_* to out_* or from out_ready to in_ready.
// TESTING
//  - Single packet: in_valid[2]=1, wid=1, tmask=4'b1011, eop=1, out_ready=1 at cycle 0 -> out_valid
//    at cycle 2, out_src=2, fields intact; cmt_valid=1, cmt_count=3 at cycle 3; busy=0 at cycle 3.
//  - Fairness: all 5 inputs push one packet each cycle, NUM_OUTPUTS=1 -> out_src sequence 0,1,2,3,4,0
//    ..., each input ready duty 1/5 after buffers fill, no input starved.
//  - Backpressure: out_ready=0 for 10 cycles with input 0 streaming -> in_ready[0] low after
//    BUF_DEPTH+1 accepts, out fields held stable; release -> packets emerge in order, none lost.
//  - Dual port: NUM_OUTPUTS=2, inputs 1 and 3 valid, rr_ptr=2 -> slot0 gets src 3, slot1 src 1;
//    rr_ptr becomes 2; tmask 1111 and 0001, both eop -> cmt_count=5.
//  - Reset mid-stream: assert reset with 3 packets buffered and out_valid=1 -> next cycle out_valid=0,
//    busy=0, cmt_count=0; first post-reset packet arbitrated from rr_ptr=0.
//  - Non-eop beat: lsu packet eop=0 then eop=1, tmask 1111 -> cmt_count 0 then 4.

Source files
------------

// File: rtl/vx_commit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vx_commit_arbiter
//  Description : Commit/writeback merger. Per-source elastic buffers feed
//                NUM_OUTPUTS registered writeback slots through a round-robin
//                allocator. Registered retired-thread statistics are produced
//                for the instret counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module vx_commit_arbiter #(
    parameter int NUM_INPUTS  = 5,
    parameter int NUM_OUTPUTS = 1,
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int BUF_DEPTH   = 2,
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int SW = $clog2(NUM_INPUTS),
    localparam int CW = $clog2(NUM_OUTPUTS * NUM_THREADS + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_INPUTS-1:0]                 in_valid,
    output logic [NUM_INPUTS-1:0]                 in_ready,
    input  logic [NUM_INPUTS*WW-1:0]              in_wid,
    input  logic [NUM_INPUTS*NUM_THREADS-1:0]     in_tmask,
    input  logic [NUM_INPUTS*32-1:0]              in_pc,
    input  logic [NUM_INPUTS*5-1:0]               in_rd,
    input  logic [NUM_INPUTS-1:0]                 in_wb,
    input  logic [NUM_INPUTS*NUM_THREADS*32-1:0]  in_data,
    input  logic [NUM_INPUTS-1:0]                 in_eop,
    output logic [NUM_OUTPUTS-1:0]                out_valid,
    input  logic [NUM_OUTPUTS-1:0]                out_ready,
    output logic [NUM_OUTPUTS*SW-1:0]             out_src,
    output logic [NUM_OUTPUTS*WW-1:0]             out_wid,
    output logic [NUM_OUTPUTS*NUM_THREADS-1:0]    out_tmask,
    output logic [NUM_OUTPUTS*32-1:0]             out_pc,
    output logic [NUM_OUTPUTS*5-1:0]              out_rd,
    output logic [NUM_OUTPUTS-1:0]                out_wb,
    output logic [NUM_OUTPUTS*NUM_THREADS*32-1:0] out_data,
    output logic [NUM_OUTPUTS-1:0]                out_eop,
    output logic                                  cmt_valid,
    output logic [CW-1:0]                         cmt_count,
    output logic                                  busy
);

    // Packet layout (LSB first): eop, data, wb, rd, pc, tmask, wid
    localparam int c_dw    = NUM_THREADS * 32;
    localparam int c_o_dat = 1;
    localparam int c_o_wb  = c_o_dat + c_dw;
    localparam int c_o_rd  = c_o_wb + 1;
    localparam int c_o_pc  = c_o_rd + 5;
    localparam int c_o_tm  = c_o_pc + 32;
    localparam int c_o_wid = c_o_tm + NUM_THREADS;
    localparam int c_pkt   = c_o_wid + WW;
    localparam int c_aw    = $clog2(BUF_DEPTH);
    localparam int c_cntw  = $clog2(BUF_DEPTH + 1);

    logic [c_pkt-1:0]       w_head [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]  w_nonempty;
    logic [NUM_INPUTS-1:0]  w_pop;

    logic [NUM_OUTPUTS-1:0] w_loadable;
    logic [NUM_OUTPUTS-1:0] w_assigned;
    logic [SW-1:0]          w_sel [NUM_OUTPUTS];
    logic                   w_any;
    logic [SW-1:0]          w_last;

    logic [SW-1:0]          r_rr_ptr;
    logic [NUM_OUTPUTS-1:0] r_out_valid;
    logic [c_pkt-1:0]       r_out_pkt [NUM_OUTPUTS];
    logic [SW-1:0]          r_out_src [NUM_OUTPUTS];
    logic                   r_cmt_valid;
    logic [CW-1:0]          r_cmt_count;
    logic                   w_cmt_any;
    logic [CW-1:0]          w_cmt_sum;

    // ------------------------------------------------------------------
    // Per-source elastic buffers
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_buf
        logic [c_pkt-1:0]  r_mem [BUF_DEPTH];
        logic [c_aw-1:0]   r_wr_ptr;
        logic [c_aw-1:0]   r_rd_ptr;
        logic [c_cntw-1:0] r_count;
        logic [c_pkt-1:0]  w_in_pkt;
        logic              w_push;

        assign w_in_pkt = {in_wid[gi*WW +: WW],
                           in_tmask[gi*NUM_THREADS +: NUM_THREADS],
                           in_pc[gi*32 +: 32],
                           in_rd[gi*5 +: 5],
                           in_wb[gi],
                           in_data[gi*c_dw +: c_dw],
                           in_eop[gi]};

        // Ready comes only from the registered count, so a same-cycle pop
        // never opens an extra slot and out_ready cannot reach in_ready.
        assign in_ready[gi]   = ~reset & (r_count != c_cntw'(BUF_DEPTH));
        assign w_push         = in_valid[gi] & in_ready[gi];
        assign w_nonempty[gi] = (r_count != '0);
        assign w_head[gi]     = r_mem[r_rd_ptr];

        // Pointer/count bookkeeping; depth is a power of two so pointers wrap naturally
        always_ff @(posedge clk) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop[gi]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop[gi]) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop[gi]) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end

        // Payload storage, no reset needed: occupancy is tracked by r_count
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in_pkt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin slot allocation
    // ------------------------------------------------------------------
    assign w_loadable = ~r_out_valid | out_ready;

    // Scan sources from r_rr_ptr; each non-empty head takes the lowest free loadable slot
    always_comb begin
        logic [SW:0]   v_sum;
        logic [SW-1:0] v_idx;
        logic          v_found;
        w_assigned = '0;
        w_pop      = '0;
        w_any      = 1'b0;
        w_last     = '0;
        v_sum      = '0;
        v_idx      = '0;
        v_found    = 1'b0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            w_sel[k] = '0;
        end
        for (int j = 0; j < NUM_INPUTS; j++) begin
            v_sum = {1'b0, r_rr_ptr} + (SW+1)'(j);
            if (v_sum >= (SW+1)'(NUM_INPUTS)) begin
                v_sum = v_sum - (SW+1)'(NUM_INPUTS);
            end
            v_idx   = v_sum[SW-1:0];
            v_found = 1'b0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (!v_found && w_nonempty[v_idx] && w_loadable[k] && !w_assigned[k]) begin
                    w_assigned[k] = 1'b1;
                    w_sel[k]      = v_idx;
                    w_pop[v_idx]  = 1'b1;
                    w_any         = 1'b1;
                    w_last        = v_idx;
                    v_found       = 1'b1;
                end
            end
        end
    end

    // Round-robin pointer advances past the last source granted this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= (w_last == SW'(NUM_INPUTS - 1)) ? '0 : w_last + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Writeback slots: load when empty or draining, hold under backpressure
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= '0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                r_out_pkt[k] <= '0;
                r_out_src[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (w_loadable[k]) begin
                    r_out_valid[k] <= w_assigned[k];
                    if (w_assigned[k]) begin
                        r_out_pkt[k] <= w_head[w_sel[k]];
                        r_out_src[k] <= w_sel[k];
                    end
                end
            end
        end
    end

    for (genvar gk = 0; gk < NUM_OUTPUTS; gk++) begin : g_out
        assign out_src[gk*SW +: SW]                     = r_out_src[gk];
        assign out_wid[gk*WW +: WW]                     = r_out_pkt[gk][c_o_wid +: WW];
        assign out_tmask[gk*NUM_THREADS +: NUM_THREADS] = r_out_pkt[gk][c_o_tm +: NUM_THREADS];
        assign out_pc[gk*32 +: 32]                      = r_out_pkt[gk][c_o_pc +: 32];
        assign out_rd[gk*5 +: 5]                        = r_out_pkt[gk][c_o_rd +: 5];
        assign out_wb[gk]                               = r_out_pkt[gk][c_o_wb];
        assign out_data[gk*c_dw +: c_dw]                = r_out_pkt[gk][c_o_dat +: c_dw];
        assign out_eop[gk]                              = r_out_pkt[gk][0];
    end
    assign out_valid = r_out_valid;

    // ------------------------------------------------------------------
    // Retirement statistics
    // ------------------------------------------------------------------
    // Sum active lanes of every end-of-packet beat leaving a slot this cycle
    always_comb begin
        int v_total;
        v_total   = 0;
        w_cmt_any = 1'b0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (r_out_valid[k] && out_ready[k] && r_out_pkt[k][0]) begin
                v_total   = v_total + $countones(r_out_pkt[k][c_o_tm +: NUM_THREADS]);
                w_cmt_any = 1'b1;
            end
        end
        w_cmt_sum = CW'(v_total);
    end

    // Statistics are registered: they describe the previous cycle's retirements
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmt_valid <= 1'b0;
            r_cmt_count <= '0;
        end else begin
            r_cmt_valid <= w_cmt_any;
            r_cmt_count <= w_cmt_sum;
        end
    end

    assign cmt_valid = r_cmt_valid;
    assign cmt_count = r_cmt_count;
    assign busy      = (|w_nonempty) | (|r_out_valid);

endmodule
`default_nettype wire

// File: tb/tb_vx_commit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vx_commit_arbiter
//  Description : Directed self-checking bench for vx_commit_arbiter, with a
//                single-port instance (dut) and a dual-port instance (dut2)
//                sharing the input side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_commit_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [4:0]   in_valid, in_wb, in_eop, in_ready, in_ready2;
    logic [9:0]   in_wid;
    logic [19:0]  in_tmask;
    logic [159:0] in_pc;
    logic [24:0]  in_rd;
    logic [639:0] in_data;

    logic [0:0]   out_valid, out_ready, out_wb, out_eop;
    logic [2:0]   out_src;
    logic [1:0]   out_wid;
    logic [3:0]   out_tmask;
    logic [31:0]  out_pc;
    logic [4:0]   out_rd;
    logic [127:0] out_data;
    logic         cmt_valid, busy;
    logic [2:0]   cmt_count;

    logic [1:0]   out_valid2, out_ready2, out_wb2, out_eop2;
    logic [5:0]   out_src2;
    logic [3:0]   out_wid2;
    logic [7:0]   out_tmask2;
    logic [63:0]  out_pc2;
    logic [9:0]   out_rd2;
    logic [255:0] out_data2;
    logic         cmt_valid2, busy2;
    logic [3:0]   cmt_count2;

    vx_commit_arbiter #(.NUM_INPUTS(5), .NUM_OUTPUTS(1), .NUM_THREADS(4),
                        .NUM_WARPS(4), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_tmask(in_tmask),
        .in_pc(in_pc), .in_rd(in_rd), .in_wb(in_wb), .in_data(in_data), .in_eop(in_eop),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_wid(out_wid),
        .out_tmask(out_tmask), .out_pc(out_pc), .out_rd(out_rd), .out_wb(out_wb),
        .out_data(out_data), .out_eop(out_eop),
        .cmt_valid(cmt_valid), .cmt_count(cmt_count), .busy(busy)
    );

    vx_commit_arbiter #(.NUM_INPUTS(5), .NUM_OUTPUTS(2), .NUM_THREADS(4),
                        .NUM_WARPS(4), .BUF_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready2), .in_wid(in_wid), .in_tmask(in_tmask),
        .in_pc(in_pc), .in_rd(in_rd), .in_wb(in_wb), .in_data(in_data), .in_eop(in_eop),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_src(out_src2), .out_wid(out_wid2),
        .out_tmask(out_tmask2), .out_pc(out_pc2), .out_rd(out_rd2), .out_wb(out_wb2),
        .out_data(out_data2), .out_eop(out_eop2),
        .cmt_valid(cmt_valid2), .cmt_count(cmt_count2), .busy(busy2)
    );

    // Stimulus helpers (drive only)
    task automatic clear_inputs();
        in_valid = '0; in_wb = '0; in_eop = '0; in_wid = '0;
        in_tmask = '0; in_pc = '0; in_rd = '0; in_data = '0;
    endtask

    task automatic set_pkt(input int i, input logic [1:0] wid, input logic [3:0] tm,
                           input logic [31:0] pc, input logic [4:0] rd,
                           input logic wb, input logic eop);
        in_wid[i*2 +: 2]   = wid;
        in_tmask[i*4 +: 4] = tm;
        in_pc[i*32 +: 32]  = pc;
        in_rd[i*5 +: 5]    = rd;
        in_wb[i]           = wb;
        in_eop[i]          = eop;
        for (int l = 0; l < 4; l++) begin
            in_data[(i*4+l)*32 +: 32] = pc ^ (32'h0101_0000 * (l + 1));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        out_ready = 1'b1; out_ready2 = 2'b11;
        next_cycle(); next_cycle();
        @(negedge clk);
        checks++; if (in_ready !== 5'b00000) begin errors++; $display("FAIL reset_in_ready got %b want 00000", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0 || cmt_valid !== 1'b0 || cmt_count !== 3'd0) begin errors++;
            $display("FAIL reset_stats got busy=%b cv=%b cc=%0d want 0 0 0", busy, cmt_valid, cmt_count); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 5'b11111) begin errors++; $display("FAIL post_reset_ready got %b want 11111", in_ready); end
    endtask

    task automatic test_single();
        logic [127:0] exp_data;
        do_reset();
        out_ready = 1'b1;
        set_pkt(2, 2'd1, 4'b1011, 32'h1000_0040, 5'd7, 1'b1, 1'b1);
        in_valid = 5'b00100;
        for (int l = 0; l < 4; l++) exp_data[l*32 +: 32] = 32'h1000_0040 ^ (32'h0101_0000 * (l + 1));
        next_cycle();
        in_valid = '0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", out_valid); end
        next_cycle();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_src !== 3'd2) begin errors++;
            $display("FAIL single_out got valid=%b src=%0d want 1 2", out_valid, out_src); end
        checks++; if (out_wid !== 2'd1 || out_tmask !== 4'b1011 || out_pc !== 32'h1000_0040 ||
                      out_rd !== 5'd7 || out_wb !== 1'b1 || out_eop !== 1'b1) begin errors++;
            $display("FAIL single_fields got wid=%0d tm=%b pc=%h rd=%0d wb=%b eop=%b want 1 1011 10000040 7 1 1",
                     out_wid, out_tmask, out_pc, out_rd, out_wb, out_eop); end
        checks++; if (out_data !== exp_data) begin errors++; $display("FAIL single_data got %h want %h", out_data, exp_data); end
        next_cycle();
        @(negedge clk);
        checks++; if (cmt_valid !== 1'b1 || cmt_count !== 3'd3) begin errors++;
            $display("FAIL single_cmt got cv=%b cc=%0d want 1 3", cmt_valid, cmt_count); end
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++;
            $display("FAIL single_idle got busy=%b valid=%b want 0 0", busy, out_valid); end
    endtask

    task automatic test_fairness();
        int seq [5];
        int oseq [5];
        int acc [5];
        int exp_src;
        int drained;
        do_reset();
        out_ready = 1'b1;
        exp_src = 0;
        for (int i = 0; i < 5; i++) begin seq[i] = 0; oseq[i] = 0; acc[i] = 0; end
        for (int cyc = 0; cyc < 40; cyc++) begin
            for (int i = 0; i < 5; i++) set_pkt(i, 2'(i), 4'b0001, {8'(i), 24'(seq[i])}, 5'(i), 1'b1, 1'b1);
            in_valid = 5'b11111;
            @(negedge clk);
            if (cyc >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_src !== 3'(exp_src) || out_pc !== {8'(exp_src), 24'(oseq[exp_src])}) begin
                    errors++;
                    $display("FAIL fair_cyc%0d got valid=%b src=%0d pc=%h want 1 %0d %h", cyc, out_valid, out_src,
                             out_pc, exp_src, {8'(exp_src), 24'(oseq[exp_src])});
                end
                oseq[exp_src]++;
                exp_src = (exp_src + 1) % 5;
            end
            for (int i = 0; i < 5; i++) begin
                if (in_ready[i]) begin
                    seq[i]++;
                    if (cyc >= 15 && cyc < 35) acc[i]++;
                end
            end
            next_cycle();
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (acc[i] != 4) begin errors++; $display("FAIL fair_accepts%0d got %0d want 4", i, acc[i]); end
        end
        clear_inputs();
        drained = 0;
        for (int c = 0; c < 40 && !drained; c++) begin
            @(negedge clk);
            if (!busy) drained = 1;
            next_cycle();
        end
        checks++; if (!drained) begin errors++; $display("FAIL fair_drain got busy=1 want 0 within 40 cycles"); end
    endtask

    task automatic test_backpressure();
        int accepts;
        int got;
        do_reset();
        out_ready = 1'b0;
        accepts = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            set_pkt(0, 2'd2, 4'b1111, 32'hB000_0000 + 32'(accepts), 5'd3, 1'b1, 1'b1);
            in_valid = 5'b00001;
            @(negedge clk);
            if (in_ready[0]) accepts++;
            if (cyc >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'hB000_0000 || out_tmask !== 4'b1111) begin errors++;
                    $display("FAIL bp_hold_cyc%0d got valid=%b pc=%h want 1 b0000000", cyc, out_valid, out_pc); end
            end
            next_cycle();
        end
        checks++; if (accepts != 3) begin errors++; $display("FAIL bp_accepts got %0d want 3", accepts); end
        @(negedge clk);
        checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", in_ready[0]); end
        next_cycle();
        clear_inputs();
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                checks++;
                if (out_pc !== 32'hB000_0000 + 32'(got)) begin errors++;
                    $display("FAIL bp_order%0d got %h want %h", got, out_pc, 32'hB000_0000 + 32'(got)); end
                got++;
            end
            next_cycle();
        end
        checks++; if (got != 3 || busy !== 1'b0) begin errors++;
            $display("FAIL bp_drain got n=%0d busy=%b want 3 0", got, busy); end
    endtask

    task automatic test_dual();
        do_reset();
        out_ready = 1'b1; out_ready2 = 2'b11;
        set_pkt(1, 2'd0, 4'b0001, 32'h0000_0111, 5'd1, 1'b1, 1'b1);
        in_valid = 5'b00010;
        next_cycle();
        in_valid = '0;
        next_cycle(); next_cycle(); next_cycle();
        set_pkt(3, 2'd3, 4'b1111, 32'h0000_0333, 5'd3, 1'b1, 1'b1);
        set_pkt(1, 2'd1, 4'b0001, 32'h0000_0222, 5'd1, 1'b1, 1'b1);
        in_valid = 5'b01010;
        next_cycle();
        in_valid = '0;
        next_cycle();
        @(negedge clk);
        checks++; if (out_valid2 !== 2'b11 || out_src2[2:0] !== 3'd3 || out_src2[5:3] !== 3'd1) begin errors++;
            $display("FAIL dual_grant got valid=%b s0=%0d s1=%0d want 11 3 1", out_valid2, out_src2[2:0], out_src2[5:3]); end
        checks++; if (out_pc2[31:0] !== 32'h0000_0333 || out_pc2[63:32] !== 32'h0000_0222) begin errors++;
            $display("FAIL dual_pc got %h %h want 00000333 00000222", out_pc2[31:0], out_pc2[63:32]); end
        set_pkt(0, 2'd0, 4'b0011, 32'h0000_0400, 5'd4, 1'b1, 1'b1);
        set_pkt(2, 2'd2, 4'b0111, 32'h0000_0500, 5'd5, 1'b1, 1'b1);
        next_cycle();
        in_valid = 5'b00101;
        @(negedge clk);
        checks++; if (cmt_valid2 !== 1'b1 || cmt_count2 !== 4'd5) begin errors++;
            $display("FAIL dual_cmt got cv=%b cc=%0d want 1 5", cmt_valid2, cmt_count2); end
        next_cycle();
        in_valid = '0;
        next_cycle();
        @(negedge clk);
        checks++; if (out_valid2 !== 2'b11 || out_src2[2:0] !== 3'd2 || out_src2[5:3] !== 3'd0) begin errors++;
            $display("FAIL dual_rr got valid=%b s0=%0d s1=%0d want 11 2 0", out_valid2, out_src2[2:0], out_src2[5:3]); end
        next_cycle();
        @(negedge clk);
        checks++; if (cmt_count2 !== 4'd5) begin errors++; $display("FAIL dual_cmt2 got %0d want 5", cmt_count2); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_pkt(i, 2'd0, 4'b1111, 32'h0000_0C00 + 32'(i), 5'(i), 1'b1, 1'b1);
        in_valid = 5'b01111;
        next_cycle();
        in_valid = '0;
        next_cycle();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL mid_pre got valid=%b busy=%b want 1 1", out_valid, busy); end
        next_cycle();
        reset = 1'b1;
        out_ready = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || cmt_count !== 3'd0 || cmt_valid !== 1'b0) begin errors++;
            $display("FAIL mid_flush got valid=%b busy=%b cc=%0d cv=%b want 0 0 0 0", out_valid, busy, cmt_count, cmt_valid); end
        checks++; if (in_ready !== 5'b11111) begin errors++; $display("FAIL mid_ready got %b want 11111", in_ready); end
        next_cycle();
        set_pkt(0, 2'd0, 4'b0001, 32'h0000_0D00, 5'd1, 1'b1, 1'b1);
        set_pkt(4, 2'd0, 4'b0001, 32'h0000_0D04, 5'd2, 1'b1, 1'b1);
        in_valid = 5'b10001;
        next_cycle();
        in_valid = '0;
        next_cycle();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_src !== 3'd0) begin errors++;
            $display("FAIL mid_rr_first got valid=%b src=%0d want 1 0", out_valid, out_src); end
        next_cycle();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_src !== 3'd4) begin errors++;
            $display("FAIL mid_rr_second got valid=%b src=%0d want 1 4", out_valid, out_src); end
    endtask

    task automatic test_non_eop();
        do_reset();
        out_ready = 1'b1;
        set_pkt(1, 2'd2, 4'b1111, 32'h0000_0E00, 5'd9, 1'b1, 1'b0);
        in_valid = 5'b00010;
        next_cycle();
        set_pkt(1, 2'd2, 4'b1111, 32'h0000_0E00, 5'd9, 1'b1, 1'b1);
        next_cycle();
        in_valid = '0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_eop !== 1'b0) begin errors++;
            $display("FAIL noneop_beat0 got valid=%b eop=%b want 1 0", out_valid, out_eop); end
        next_cycle();
        @(negedge clk);
        checks++; if (cmt_valid !== 1'b0 || cmt_count !== 3'd0) begin errors++;
            $display("FAIL noneop_cmt0 got cv=%b cc=%0d want 0 0", cmt_valid, cmt_count); end
        next_cycle();
        @(negedge clk);
        checks++; if (cmt_valid !== 1'b1 || cmt_count !== 3'd4) begin errors++;
            $display("FAIL noneop_cmt1 got cv=%b cc=%0d want 1 4", cmt_valid, cmt_count); end
    endtask

    initial begin
        clear_inputs();
        out_ready  = 1'b1;
        out_ready2 = 2'b11;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_dual();
        test_reset_mid();
        test_non_eop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
